// File: rtl/frame_color_classifier_if.sv
// Pixel stream from the frame-buffer read port plus the classifier's results.
// The master drives scan coordinates and pixel data; the slave is the classifier.
interface frame_color_classifier_if;
   logic [7:0]  pixel;
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;
   logic [2:0]  result;
   logic [14:0] red_count;
   logic [14:0] blue_count;
   logic        frame_done;

   modport master (
      output pixel, vga_x, vga_y,
      input  result, red_count, blue_count, frame_done
   );

   modport slave (
      input  pixel, vga_x, vga_y,
      output result, red_count, blue_count, frame_done
   );
endinterface

// File: rtl/frame_color_classifier.sv
// Counts red- and blue-dominant RGB332 pixels inside the image window each frame,
// then classifies the frame and debounces that decision across consecutive frames.
module frame_color_classifier #(
   parameter int unsigned SCREEN_WIDTH   = 176,
   parameter int unsigned SCREEN_HEIGHT  = 144,
   parameter logic [2:0]  RED_MIN        = 3'd5,
   parameter logic [1:0]  BLUE_MIN       = 2'd2,
   parameter logic [2:0]  OTHER_MAX      = 3'd3,
   parameter logic [14:0] COUNT_THRESH   = 15'd2000,
   parameter int unsigned CONFIRM_FRAMES = 3
) (
   input logic                     clk_i,
   input logic                     rst_i,
   frame_color_classifier_if.slave pix_if
);
   localparam logic [9:0]  WIDTH_L   = 10'(SCREEN_WIDTH);
   localparam logic [9:0]  HEIGHT_L  = 10'(SCREEN_HEIGHT);
   localparam logic [2:0]  CONFIRM_L = 3'(CONFIRM_FRAMES);
   localparam logic [14:0] ACC_MAX   = 15'h7FFF;

   typedef enum logic [2:0] {
      CLS_NONE = 3'b000,
      CLS_RED  = 3'b110,
      CLS_BLUE = 3'b111
   } class_e;

   logic [9:0]  xd_q, yd_q, yd_prev_q;
   logic [14:0] red_acc_q, red_acc_d, blue_acc_q, blue_acc_d;
   logic [14:0] red_count_q, red_count_d, blue_count_q, blue_count_d;
   class_e      result_q, result_d, cand_prev_q, cand_prev_d, candidate;
   logic [2:0]  streak_q, streak_d;
   logic        frame_done_q;
   logic        in_window, is_red, is_blue, frame_end;
   logic [2:0]  px_r, px_g;
   logic [1:0]  px_b;

   assign px_r = pix_if.pixel[7:5];
   assign px_g = pix_if.pixel[4:2];
   assign px_b = pix_if.pixel[1:0];

   // Pixel data lags its coordinates by one cycle, so classify against the registered scan position.
   assign in_window = (xd_q < WIDTH_L) && (yd_q < HEIGHT_L);
   assign is_red    = in_window && (px_r >= RED_MIN) && (px_g <= OTHER_MAX) && (px_b <= 2'd1);
   assign is_blue   = in_window && (px_b >= BLUE_MIN) && (px_r <= OTHER_MAX) && (px_g <= OTHER_MAX);
   assign frame_end = (yd_q == HEIGHT_L) && (yd_prev_q == HEIGHT_L - 10'd1);

   always_comb begin
      candidate = CLS_NONE;
      if (red_acc_q > COUNT_THRESH && red_acc_q > blue_acc_q) begin
         candidate = CLS_RED;
      end else if (blue_acc_q > COUNT_THRESH && blue_acc_q > red_acc_q) begin
         candidate = CLS_BLUE;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path through this block can infer a latch.
      red_acc_d    = red_acc_q;
      blue_acc_d   = blue_acc_q;
      red_count_d  = red_count_q;
      blue_count_d = blue_count_q;
      cand_prev_d  = cand_prev_q;
      streak_d     = streak_q;
      result_d     = result_q;

      if (frame_end) begin
         red_count_d  = red_acc_q;
         blue_count_d = blue_acc_q;
         red_acc_d    = '0;
         blue_acc_d   = '0;
         if (candidate == cand_prev_q) begin
            streak_d = (streak_q >= CONFIRM_L) ? CONFIRM_L : streak_q + 3'd1;
         end else begin
            cand_prev_d = candidate;
            streak_d    = 3'd1;
         end
         if (streak_d == CONFIRM_L) begin
            result_d = candidate;
         end
      end else begin
         if (is_red && red_acc_q != ACC_MAX) begin
            red_acc_d = red_acc_q + 15'd1;
         end
         if (is_blue && blue_acc_q != ACC_MAX) begin
            blue_acc_d = blue_acc_q + 15'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         xd_q         <= '0;
         yd_q         <= '0;
         yd_prev_q    <= '0;
         red_acc_q    <= '0;
         blue_acc_q   <= '0;
         red_count_q  <= '0;
         blue_count_q <= '0;
         cand_prev_q  <= CLS_NONE;
         streak_q     <= '0;
         result_q     <= CLS_NONE;
         frame_done_q <= 1'b0;
      end else begin
         xd_q         <= pix_if.vga_x;
         yd_q         <= pix_if.vga_y;
         yd_prev_q    <= yd_q;
         red_acc_q    <= red_acc_d;
         blue_acc_q   <= blue_acc_d;
         red_count_q  <= red_count_d;
         blue_count_q <= blue_count_d;
         cand_prev_q  <= cand_prev_d;
         streak_q     <= streak_d;
         result_q     <= result_d;
         frame_done_q <= frame_end;
      end
   end

   assign pix_if.result     = result_q;
   assign pix_if.red_count  = red_count_q;
   assign pix_if.blue_count = blue_count_q;
   assign pix_if.frame_done = frame_done_q;
endmodule

// File: tb/tb_frame_color_classifier.sv
// Directed bench: a default instance (3-frame debounce) and a 1-frame-debounce instance
// receive the same scan stream; each scenario task checks its own expected values.
module tb_frame_color_classifier;
   logic       clk = 1'b0;
   logic       rst_a;
   logic       rst_c1;
   logic [7:0] pend_pix;
   int         checks = 0;
   int         errors = 0;

   frame_color_classifier_if bus_a ();
   frame_color_classifier_if bus_c1 ();

   frame_color_classifier dut_a (
      .clk_i  (clk),
      .rst_i  (rst_a),
      .pix_if (bus_a)
   );

   frame_color_classifier #(.CONFIRM_FRAMES(1)) dut_c1 (
      .clk_i  (clk),
      .rst_i  (rst_c1),
      .pix_if (bus_c1)
   );

   always #5 clk = ~clk;

   // Present new coordinates and, in the same cycle, the pixel for the previous coordinates.
   task automatic step(input int x, input int y, input logic [7:0] pix);
      @(negedge clk);
      bus_a.vga_x  = 10'(x);
      bus_a.vga_y  = 10'(y);
      bus_a.pixel  = pend_pix;
      bus_c1.vga_x = 10'(x);
      bus_c1.vga_y = 10'(y);
      bus_c1.pixel = pend_pix;
      pend_pix     = pix;
   endtask

   task automatic fill(input int first, input int n, input logic [7:0] pix);
      for (int i = first; i < first + n; i++) step(i % 176, i / 176, pix);
   endtask

   // Returns in the cycle where FRAME_DONE should be high.
   task automatic end_frame();
      step(0, 143, 8'h00);
      step(0, 144, 8'h00);
      step(0, 144, 8'h00);
      step(0, 144, 8'h00);
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_c1 = 1'b1; pend_pix = 8'h00;
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      #1; rst_a = 1'b0; rst_c1 = 1'b0;
      fill(0, 100, 8'hE0);
      rst_a = 1'b1; rst_c1 = 1'b1;
      #1;
      checks++;
      if ({bus_a.result, bus_a.red_count, bus_a.blue_count, bus_a.frame_done} !== 34'd0) begin
         errors++; $display("FAIL reset_outputs_a got %h want 0", {bus_a.result, bus_a.red_count, bus_a.blue_count, bus_a.frame_done});
      end
      checks++;
      if ({bus_c1.result, bus_c1.red_count, bus_c1.blue_count, bus_c1.frame_done} !== 34'd0) begin
         errors++; $display("FAIL reset_outputs_c1 got %h want 0", {bus_c1.result, bus_c1.red_count, bus_c1.blue_count, bus_c1.frame_done});
      end
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      #1; rst_a = 1'b0; rst_c1 = 1'b0;
      for (int f = 0; f < 3; f++) begin
         fill(0, 50, 8'h00);
         end_frame();
         checks++;
         if (bus_a.frame_done !== 1'b1) begin errors++; $display("FAIL idle_f%0d_done got %b want 1", f, bus_a.frame_done); end
         checks++;
         if (bus_a.red_count !== 15'd0 || bus_a.blue_count !== 15'd0) begin
            errors++; $display("FAIL idle_f%0d_counts got %0d/%0d want 0/0", f, bus_a.red_count, bus_a.blue_count);
         end
         checks++;
         if (bus_a.result !== 3'b000 || bus_c1.result !== 3'b000) begin
            errors++; $display("FAIL idle_f%0d_result got %b/%b want 000/000", f, bus_a.result, bus_c1.result);
         end
      end
   endtask

   task automatic test_full_red();
      int         n_red [3]   = '{25344, 2500, 2500};
      logic [2:0] exp_a [3]   = '{3'b000, 3'b000, 3'b110};
      for (int f = 0; f < 3; f++) begin
         fill(0, n_red[f], 8'hE0);
         end_frame();
         checks++;
         if (bus_a.frame_done !== 1'b1) begin errors++; $display("FAIL red_f%0d_done got %b want 1", f, bus_a.frame_done); end
         checks++;
         if (bus_a.red_count !== 15'(n_red[f]) || bus_a.blue_count !== 15'd0) begin
            errors++; $display("FAIL red_f%0d_counts got %0d/%0d want %0d/0", f, bus_a.red_count, bus_a.blue_count, n_red[f]);
         end
         checks++;
         if (bus_a.result !== exp_a[f]) begin errors++; $display("FAIL red_f%0d_result_a got %b want %b", f, bus_a.result, exp_a[f]); end
         checks++;
         if (bus_c1.result !== 3'b110) begin errors++; $display("FAIL red_f%0d_result_c1 got %b want 110", f, bus_c1.result); end
      end
      step(0, 144, 8'h00);
      checks++;
      if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL red_done_width got %b want 0", bus_a.frame_done); end
   endtask

   task automatic test_blue_threshold();
      logic [2:0] exp_a  [6] = '{3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b111};
      logic [2:0] exp_c1 [6] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
      for (int f = 0; f < 6; f++) begin
         int n;
         n = (f < 3) ? 2000 : 2001;
         fill(0, n, 8'h03);
         end_frame();
         checks++;
         if (bus_a.blue_count !== 15'(n) || bus_a.red_count !== 15'd0) begin
            errors++; $display("FAIL blue_f%0d_counts got %0d/%0d want 0/%0d", f, bus_a.red_count, bus_a.blue_count, n);
         end
         checks++;
         if (bus_a.result !== exp_a[f] || bus_c1.result !== exp_c1[f]) begin
            errors++; $display("FAIL blue_f%0d_result got %b/%b want %b/%b", f, bus_a.result, bus_c1.result, exp_a[f], exp_c1[f]);
         end
      end
   endtask

   task automatic test_tie();
      fill(0, 5000, 8'hE0);
      fill(5000, 5000, 8'h03);
      end_frame();
      checks++;
      if (bus_a.red_count !== 15'd5000 || bus_a.blue_count !== 15'd5000) begin
         errors++; $display("FAIL tie_counts got %0d/%0d want 5000/5000", bus_a.red_count, bus_a.blue_count);
      end
      checks++;
      if (bus_a.result !== 3'b111 || bus_c1.result !== 3'b000) begin
         errors++; $display("FAIL tie_result got %b/%b want 111/000", bus_a.result, bus_c1.result);
      end
   endtask

   task automatic test_flicker();
      for (int f = 0; f < 4; f++) begin
         logic       is_red_frame;
         logic [2:0] exp_c1;
         is_red_frame = (f % 2 == 0);
         exp_c1 = is_red_frame ? 3'b110 : 3'b111;
         fill(0, 2100, is_red_frame ? 8'hE0 : 8'h03);
         end_frame();
         checks++;
         if (bus_a.red_count !== (is_red_frame ? 15'd2100 : 15'd0) || bus_a.blue_count !== (is_red_frame ? 15'd0 : 15'd2100)) begin
            errors++; $display("FAIL flicker_f%0d_counts got %0d/%0d", f, bus_a.red_count, bus_a.blue_count);
         end
         checks++;
         if (bus_a.result !== 3'b111 || bus_c1.result !== exp_c1) begin
            errors++; $display("FAIL flicker_f%0d_result got %b/%b want 111/%b", f, bus_a.result, bus_c1.result, exp_c1);
         end
      end
   endtask

   task automatic test_window();
      for (int x = 176; x < 640; x++) step(x, 10, 8'hE0);
      for (int x = 0; x < 100; x++) step(x, 150, 8'hE0);
      for (int x = 0; x < 10; x++) step(x, 524, 8'hE0);
      step(175, 143, 8'hE0);
      end_frame();
      checks++;
      if (bus_a.red_count !== 15'd1 || bus_c1.red_count !== 15'd1 || bus_a.blue_count !== 15'd0) begin
         errors++; $display("FAIL window_counts got %0d/%0d/%0d want 1/1/0", bus_a.red_count, bus_c1.red_count, bus_a.blue_count);
      end
      checks++;
      if (bus_a.result !== 3'b111 || bus_c1.result !== 3'b000) begin
         errors++; $display("FAIL window_result got %b/%b want 111/000", bus_a.result, bus_c1.result);
      end
   endtask

   task automatic test_confirm1_reset();
      fill(0, 300, 8'hE0);
      rst_c1 = 1'b1;
      #1;
      checks++;
      if (bus_c1.red_count !== 15'd0 || bus_c1.result !== 3'b000) begin
         errors++; $display("FAIL c1_reset got %0d/%b want 0/000", bus_c1.red_count, bus_c1.result);
      end
      fill(300, 2, 8'h00);
      #1; rst_c1 = 1'b0;
      fill(302, 2100, 8'hE0);
      end_frame();
      checks++;
      if (bus_c1.frame_done !== 1'b1) begin errors++; $display("FAIL c1_done got %b want 1", bus_c1.frame_done); end
      checks++;
      if (bus_a.red_count !== 15'd2400 || bus_c1.red_count !== 15'd2100) begin
         errors++; $display("FAIL c1_partial_counts got %0d/%0d want 2400/2100", bus_a.red_count, bus_c1.red_count);
      end
      checks++;
      if (bus_a.result !== 3'b111 || bus_c1.result !== 3'b110) begin
         errors++; $display("FAIL c1_result got %b/%b want 111/110", bus_a.result, bus_c1.result);
      end
   endtask

   initial begin
      bus_a.pixel = 8'h00; bus_a.vga_x = '0; bus_a.vga_y = '0;
      bus_c1.pixel = 8'h00; bus_c1.vga_x = '0; bus_c1.vga_y = '0;
      test_reset();
      test_full_red();
      test_blue_threshold();
      test_tie();
      test_flicker();
      test_window();
      test_confirm1_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_color_classifier.md
# frame_color_classifier

Downstream consumer of the M9K frame buffer's read port. It samples each RGB332 pixel as the VGA driver scans it out, and counts red-dominant and blue-dominant pixels inside the 176×144 image window. At every frame end it classifies the frame as red, blue or none, debounces that decision across consecutive frames, and drives the 3-bit RESULT code. The top level decodes RESULT onto the treasure-indicator GPIO pins.

## Interface
- SCREEN_WIDTH, 176: image window width in pixels (X = 0..SCREEN_WIDTH-1)
- SCREEN_HEIGHT, 144: image window height in lines (Y = 0..SCREEN_HEIGHT-1)
- RED_MIN, 3'd5: minimum R field for a red pixel
- BLUE_MIN, 2'd2: minimum B field for a blue pixel
- OTHER_MAX, 3'd3: maximum allowed value of each non-dominant field (R, G, or B zero-extended to 3 bits)
- COUNT_THRESH, 15'd2000: a colour's per-frame count must strictly exceed this value to win
- CONFIRM_FRAMES, 3: consecutive identical candidates required before RESULT changes (range 1..7)
- CLK  input  1  pixel clock, the 25 MHz VGA clock; all logic is on the rising edge
- RESET  input  1  asynchronous, active-high; clears all state
- PIXEL_IN  input  8  RGB332 from the frame buffer read port ({R[2:0],G[2:0],B[1:0]}); valid one cycle after its coordinates
- VGA_PIXEL_X  input  10  current VGA scan X; advances by one per CLK
- VGA_PIXEL_Y  input  10  current VGA scan Y
- RESULT  output  3  debounced classification: 3'b000 none, 3'b110 red, 3'b111 blue
- RED_COUNT  output  15  red-pixel total of the last completed frame
- BLUE_COUNT  output  15  blue-pixel total of the last completed frame
- FRAME_DONE  output  1  one-cycle pulse in the cycle after each frame-end evaluation

## Operation
- Coordinate alignment
  - X and Y are registered once (Xd, Yd) to match the one-cycle M9K read latency.
  - PIXEL_IN in cycle n belongs to (Xd, Yd) in cycle n.
- In-window
  - Xd < SCREEN_WIDTH and Yd < SCREEN_HEIGHT.
  - Out-of-window pixels are ignored.
- Pixel classes (in-window only; mutually exclusive by construction)
  - Red: R ≥ RED_MIN, G ≤ OTHER_MAX, B ≤ 1.
  - Blue: B ≥ BLUE_MIN, R ≤ OTHER_MAX, G ≤ OTHER_MAX.
- Accumulators
  - red_acc and blue_acc are 15 bits wide, +1 per classified pixel.
  - Each saturates at 15'h7FFF and never wraps.
- Frame-end event E
  - E is true in the cycle where Yd == SCREEN_HEIGHT and the previous Yd == SCREEN_HEIGHT-1. It fires exactly once per frame.
  - On E:
    - RED_COUNT ← red_acc and BLUE_COUNT ← blue_acc.
    - Both accumulators clear to 0.
    - A candidate is computed from the pre-clear accumulator values:
      - red (110) if red_acc > COUNT_THRESH and red_acc > blue_acc;
      - blue (111) if blue_acc > COUNT_THRESH and blue_acc > red_acc;
      - else none (000), which includes equal counts.
- Debounce, using registers cand_prev[2:0] and streak[2:0]
  - On E, if candidate == cand_prev: streak ← min(streak+1, CONFIRM_FRAMES).
  - Otherwise: cand_prev ← candidate and streak ← 1.
  - RESULT ← candidate when the new streak value equals CONFIRM_FRAMES; otherwise RESULT holds.
- Reset values
  - RESULT=000, RED_COUNT=0, BLUE_COUNT=0, FRAME_DONE=0.
  - Accumulators, Xd, Yd, previous-Yd, cand_prev=000, streak=0.
  - A reset mid-frame discards the partial counts. The first E after reset evaluates only the pixels seen since reset.

## Timing
- Pixel to accumulator: the count includes a pixel at the first edge after its PIXEL_IN cycle.
- E occurs one cycle after the VGA driver presents Y == SCREEN_HEIGHT, because of the Xd/Yd register.
- On the clock edge that ends cycle E, RED_COUNT, BLUE_COUNT, RESULT, streak and cand_prev all update together.
- FRAME_DONE is high for exactly the following cycle.
- RESULT latency from the first frame of a new colour: CONFIRM_FRAMES frame ends.
- No pixel is classified in cycle E (it is out-of-window), so accumulate and clear never collide.
- The design must meet 25 MHz. The class compare, accumulator increment and E detect each fit within one cycle.

## Test plan
- Reset then idle:
  - Assert RESET mid-scan.
  - All outputs are 0. After release, RESULT stays 000 through 3 frames of black (8'h00), with RED_COUNT = BLUE_COUNT = 0 each frame.
- Full red frames:
  - Drive PIXEL_IN = 8'hE0 for 3 frames.
  - Each FRAME_DONE shows RED_COUNT = 25344 and BLUE_COUNT = 0.
  - RESULT becomes 110 only after the 3rd frame end.
- Blue region vs threshold:
  - 2000 blue pixels (8'h03) per frame: RESULT stays 000.
  - 2001 blue pixels per frame: RESULT becomes 111 after 3 frames.
  - BLUE_COUNT matches exactly in both cases.
- Tie and flicker:
  - 5000 red and 5000 blue pixels per frame: RESULT stays 000.
  - Alternating all-red and all-blue frames: RESULT never changes from its prior value.
- Out-of-window and latency alignment:
  - Red pixels placed only at X = 176..639 or Y ≥ 144 are not counted.
  - A single red pixel at (175,143), presented one cycle after those coordinates, gives RED_COUNT = 1.
- CONFIRM_FRAMES = 1, with RESET asserted mid-frame:
  - RESULT follows the candidate every frame.
  - The partial-frame count after reset equals only the post-reset pixels.
